// File: rtl/mbinit_sb_pkg.sv
// Shared constants, message codes and FSM encoding for the MBINIT sideband
// PARAM message decoder.
package mbinit_sb_pkg;

    localparam logic [4:0] OP_MSG_NODATA = 5'b10010;
    localparam logic [4:0] OP_MSG_DATA   = 5'b11011;

    localparam logic [7:0] MC_PARAM_REQ  = 8'hA5;
    localparam logic [7:0] MC_PARAM_RESP = 8'hAA;
    localparam logic [7:0] SC_PARAM      = 8'h00;

    localparam logic [3:0] MSG_NONE       = 4'd0;
    localparam logic [3:0] MSG_PARAM_REQ  = 4'd1;
    localparam logic [3:0] MSG_PARAM_RESP = 4'd2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR1  = 3'd1,
        DATA0 = 3'd2,
        DATA1 = 3'd3,
        EMIT  = 3'd4
    } state_e;

    // MSG_NONE doubles as "unrecognised msgcode/subcode pair".
    function automatic logic [3:0] decode_msg(input logic [7:0] msgcode,
                                              input logic [7:0] subcode);
        logic [3:0] code;
        code = MSG_NONE;
        if (subcode == SC_PARAM) begin
            if (msgcode == MC_PARAM_REQ)
                code = MSG_PARAM_REQ;
            else if (msgcode == MC_PARAM_RESP)
                code = MSG_PARAM_RESP;
        end
        return code;
    endfunction

endpackage

// File: rtl/sb_parity_chk.sv
// Header (cp) and data (dp) even-parity generation; dp accumulates across the
// two 32-bit data phases.
module sb_parity_chk (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] hdr0_i,
    input  logic [29:0] hdr1_i,
    input  logic [31:0] data_i,
    input  logic        dp_clr_i,
    input  logic        dp_acc_i,
    output logic        cp_exp_o,
    output logic        dp_exp_o
);

    logic dp_acc_q;
    logic dp_acc_d;

    assign cp_exp_o = (^hdr0_i) ^ (^hdr1_i);
    // Includes the phase currently on data_i so the final check needs no extra cycle.
    assign dp_exp_o = dp_acc_q ^ (^data_i);

    always_comb begin
        dp_acc_d = dp_acc_q;
        if (dp_clr_i)
            dp_acc_d = 1'b0;
        else if (dp_acc_i)
            dp_acc_d = dp_exp_o;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            dp_acc_q <= 1'b0;
        else
            dp_acc_q <= dp_acc_d;
    end

endmodule

// File: rtl/mbinit_param_sb_decoder.sv
// Sideband packet decoder for MBINIT PARAM request/response messages: collects
// 2- or 4-phase packets, checks parity and pulses the decoded result for one cycle.
module mbinit_param_sb_decoder
    import mbinit_sb_pkg::*;
(
    input  logic        CLK,
    input  logic        rst_n,
    input  logic        i_MBINIT_Start_en,
    input  logic        i_sb_rx_valid,
    input  logic [31:0] i_sb_rx_data,
    output logic [3:0]  o_RX_SbMessage,
    output logic        o_msg_valid,
    output logic [4:0]  o_RX_VoltageSwing,
    output logic [2:0]  o_RX_MaxDataRate,
    output logic        o_RX_ClockMode,
    output logic        o_RX_PhaseClock,
    output logic        o_parity_error,
    output logic        o_unknown_msg
);

    state_e      state_q, state_d;
    logic [31:0] hdr0_q, hdr0_d;
    logic [7:0]  subcode_q, subcode_d;
    logic        dp_q, dp_d;
    logic        cp_err_q, cp_err_d;
    logic [9:0]  data0_q, data0_d;
    logic [9:0]  fields_q, fields_d;
    logic [3:0]  code_q, code_d;
    logic        msg_valid_q, msg_valid_d;
    logic        par_err_q, par_err_d;
    logic        unknown_q, unknown_d;

    logic        dp_clr, dp_acc;
    logic        cp_exp, dp_exp;
    logic        fin, fin_err, fin_data;
    logic [3:0]  fin_code;

    sb_parity_chk u_parity (
        .clk      (CLK),
        .rst_n    (rst_n),
        .hdr0_i   (hdr0_q),
        .hdr1_i   (i_sb_rx_data[29:0]),
        .data_i   (i_sb_rx_data),
        .dp_clr_i (dp_clr),
        .dp_acc_i (dp_acc),
        .cp_exp_o (cp_exp),
        .dp_exp_o (dp_exp)
    );

    always_comb begin
        state_d     = state_q;
        hdr0_d      = hdr0_q;
        subcode_d   = subcode_q;
        dp_d        = dp_q;
        cp_err_d    = cp_err_q;
        data0_d     = data0_q;
        fields_d    = fields_q;
        code_d      = MSG_NONE;
        msg_valid_d = 1'b0;
        par_err_d   = 1'b0;
        unknown_d   = 1'b0;
        dp_clr      = 1'b0;
        dp_acc      = 1'b0;
        fin         = 1'b0;
        fin_err     = 1'b0;
        fin_data    = 1'b0;
        fin_code    = MSG_NONE;

        unique case (state_q)
            // EMIT also accepts phase0 so consecutive packets need no idle cycle.
            IDLE, EMIT: begin
                state_d = IDLE;
                if (i_MBINIT_Start_en && i_sb_rx_valid) begin
                    hdr0_d  = i_sb_rx_data;
                    dp_clr  = 1'b1;
                    state_d = HDR1;
                end
            end
            HDR1: begin
                if (!i_MBINIT_Start_en) begin
                    state_d = IDLE;
                end else if (i_sb_rx_valid) begin
                    subcode_d = i_sb_rx_data[7:0];
                    dp_d      = i_sb_rx_data[31];
                    cp_err_d  = i_sb_rx_data[30] ^ cp_exp;
                    if (hdr0_q[4:0] == OP_MSG_DATA) begin
                        state_d = DATA0;
                    end else begin
                        state_d  = EMIT;
                        fin      = 1'b1;
                        // Without data the expected dp is simply 0.
                        fin_err  = (i_sb_rx_data[30] ^ cp_exp) | i_sb_rx_data[31];
                        fin_code = (hdr0_q[4:0] == OP_MSG_NODATA) ?
                                   decode_msg(hdr0_q[21:14], i_sb_rx_data[7:0]) : MSG_NONE;
                    end
                end
            end
            DATA0: begin
                if (!i_MBINIT_Start_en) begin
                    state_d = IDLE;
                end else if (i_sb_rx_valid) begin
                    data0_d = i_sb_rx_data[9:0];
                    dp_acc  = 1'b1;
                    state_d = DATA1;
                end
            end
            DATA1: begin
                if (!i_MBINIT_Start_en) begin
                    state_d = IDLE;
                end else if (i_sb_rx_valid) begin
                    state_d  = EMIT;
                    fin      = 1'b1;
                    fin_data = 1'b1;
                    fin_err  = cp_err_q | (dp_q ^ dp_exp);
                    fin_code = decode_msg(hdr0_q[21:14], subcode_q);
                end
            end
            default: state_d = IDLE;
        endcase

        // Parity errors take precedence over decode; only clean, known messages qualify.
        if (fin) begin
            if (fin_err) begin
                par_err_d = 1'b1;
            end else if (fin_code == MSG_NONE) begin
                unknown_d = 1'b1;
            end else begin
                msg_valid_d = 1'b1;
                code_d      = fin_code;
                if (fin_data)
                    fields_d = data0_q;
            end
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            hdr0_q      <= '0;
            subcode_q   <= '0;
            dp_q        <= 1'b0;
            cp_err_q    <= 1'b0;
            data0_q     <= '0;
            fields_q    <= '0;
            code_q      <= MSG_NONE;
            msg_valid_q <= 1'b0;
            par_err_q   <= 1'b0;
            unknown_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            hdr0_q      <= hdr0_d;
            subcode_q   <= subcode_d;
            dp_q        <= dp_d;
            cp_err_q    <= cp_err_d;
            data0_q     <= data0_d;
            fields_q    <= fields_d;
            code_q      <= code_d;
            msg_valid_q <= msg_valid_d;
            par_err_q   <= par_err_d;
            unknown_q   <= unknown_d;
        end
    end

    assign o_RX_SbMessage    = code_q;
    assign o_msg_valid       = msg_valid_q;
    assign o_parity_error    = par_err_q;
    assign o_unknown_msg     = unknown_q;
    assign o_RX_VoltageSwing = fields_q[4:0];
    assign o_RX_MaxDataRate  = fields_q[7:5];
    assign o_RX_ClockMode    = fields_q[8];
    assign o_RX_PhaseClock   = fields_q[9];

endmodule

// File: tb/tb_mbinit_param_sb_decoder.sv
// Directed-vector bench for the MBINIT PARAM sideband decoder.
module tb_mbinit_param_sb_decoder;

    logic        CLK;
    logic        rst_n;
    logic        i_MBINIT_Start_en;
    logic        i_sb_rx_valid;
    logic [31:0] i_sb_rx_data;
    logic [3:0]  o_RX_SbMessage;
    logic        o_msg_valid;
    logic [4:0]  o_RX_VoltageSwing;
    logic [2:0]  o_RX_MaxDataRate;
    logic        o_RX_ClockMode;
    logic        o_RX_PhaseClock;
    logic        o_parity_error;
    logic        o_unknown_msg;

    int nvec = 0;
    int nerr = 0;

    mbinit_param_sb_decoder dut (
        .CLK               (CLK),
        .rst_n             (rst_n),
        .i_MBINIT_Start_en (i_MBINIT_Start_en),
        .i_sb_rx_valid     (i_sb_rx_valid),
        .i_sb_rx_data      (i_sb_rx_data),
        .o_RX_SbMessage    (o_RX_SbMessage),
        .o_msg_valid       (o_msg_valid),
        .o_RX_VoltageSwing (o_RX_VoltageSwing),
        .o_RX_MaxDataRate  (o_RX_MaxDataRate),
        .o_RX_ClockMode    (o_RX_ClockMode),
        .o_RX_PhaseClock   (o_RX_PhaseClock),
        .o_parity_error    (o_parity_error),
        .o_unknown_msg     (o_unknown_msg)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] hdr0(input logic [7:0] mc, input logic [4:0] op);
        return {10'b0, mc, 9'b0, op};
    endfunction

    // cp covers every header bit except cp and dp themselves.
    function automatic logic [31:0] hdr1(input logic [31:0] h0, input logic [7:0] sub,
                                         input logic dp);
        logic cp;
        cp = (^h0) ^ (^sub);
        return {dp, cp, 22'b0, sub};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic v, input logic [3:0] code,
                             input logic par, input logic unk, input logic [4:0] sw,
                             input logic [2:0] rate, input logic cm, input logic ph);
        chk({tag, ".valid"}, 32'(o_msg_valid), 32'(v));
        chk({tag, ".code"},  32'(o_RX_SbMessage), 32'(code));
        chk({tag, ".parerr"}, 32'(o_parity_error), 32'(par));
        chk({tag, ".unknown"}, 32'(o_unknown_msg), 32'(unk));
        chk({tag, ".swing"}, 32'(o_RX_VoltageSwing), 32'(sw));
        chk({tag, ".rate"},  32'(o_RX_MaxDataRate), 32'(rate));
        chk({tag, ".clkmode"}, 32'(o_RX_ClockMode), 32'(cm));
        chk({tag, ".phclk"}, 32'(o_RX_PhaseClock), 32'(ph));
        $display("check %s done", tag);
    endtask

    // Present one phase; returns at the negedge following its acceptance edge.
    task automatic drive(input logic [31:0] d);
        i_sb_rx_data  = d;
        i_sb_rx_valid = 1'b1;
        @(negedge CLK);
    endtask

    task automatic send(input logic [31:0] d, input int gaps);
        drive(d);
        i_sb_rx_valid = 1'b0;
        repeat (gaps) @(negedge CLK);
    endtask

    // Last phase: EMIT outputs are visible immediately on return.
    task automatic last(input logic [31:0] d);
        drive(d);
        i_sb_rx_valid = 1'b0;
    endtask

    logic [31:0] h0_req_d, h0_resp_n, h0_resp_d, h0_unk;

    initial begin
        rst_n             = 1'b0;
        i_MBINIT_Start_en = 1'b0;
        i_sb_rx_valid     = 1'b0;
        i_sb_rx_data      = '0;
        h0_req_d  = hdr0(8'hA5, 5'b11011);
        h0_resp_n = hdr0(8'hAA, 5'b10010);
        h0_resp_d = hdr0(8'hAA, 5'b11011);
        h0_unk    = hdr0(8'h55, 5'b10010);

        repeat (2) @(negedge CLK);
        check_out("reset", 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n             = 1'b1;
        i_MBINIT_Start_en = 1'b1;
        @(negedge CLK);

        // PARAM_REQ with data 10'b1_0_011_01111 (7 ones -> dp=1)
        send(h0_req_d, 0);
        send(hdr1(h0_req_d, 8'h00, 1'b1), 0);
        send(32'h0000_026F, 0);
        check_out("req.pre", 0, 0, 0, 0, 0, 0, 0, 0);
        last(32'h0);
        check_out("req", 1, 1, 0, 0, 15, 3, 0, 1);
        @(negedge CLK);
        check_out("req.after", 0, 0, 0, 0, 15, 3, 0, 1);

        // PARAM_RESP without data: fields held
        send(h0_resp_n, 1);
        last(hdr1(h0_resp_n, 8'h00, 1'b0));
        check_out("resp_nodata", 1, 2, 0, 0, 15, 3, 0, 1);
        @(negedge CLK);

        // Data bit0 flipped (6 ones) with dp left at 1
        send(h0_req_d, 0);
        send(hdr1(h0_req_d, 8'h00, 1'b1), 0);
        send(32'h0000_026E, 0);
        last(32'h0);
        check_out("parity", 0, 0, 1, 0, 15, 3, 0, 1);
        @(negedge CLK);
        chk("parity.after", 32'(o_parity_error), 32'd0);

        // Unknown msgcode 0x55
        send(h0_unk, 0);
        last(hdr1(h0_unk, 8'h00, 1'b0));
        check_out("unknown", 0, 0, 0, 1, 15, 3, 0, 1);
        @(negedge CLK);
        chk("unknown.after", 32'(o_unknown_msg), 32'd0);

        // Back-to-back: A = PARAM_RESP data 10'b0_1_101_00011 (5 ones), 3-cycle gaps
        send(h0_resp_d, 3);
        send(hdr1(h0_resp_d, 8'h00, 1'b1), 3);
        send(32'h0000_01A3, 3);
        drive(32'h0);
        i_sb_rx_data = h0_req_d;
        check_out("b2b_a", 1, 2, 0, 0, 3, 5, 1, 0);
        drive(h0_req_d);
        chk("b2b.pulse_width", 32'(o_msg_valid), 32'd0);
        drive(hdr1(h0_req_d, 8'h00, 1'b0));
        drive(32'h0000_03FF);
        last(32'h0);
        check_out("b2b_b", 1, 1, 0, 0, 31, 7, 1, 1);
        @(negedge CLK);

        // Start_en dropped after phase 2
        send(h0_req_d, 0);
        send(hdr1(h0_req_d, 8'h00, 1'b1), 0);
        i_MBINIT_Start_en = 1'b0;
        repeat (2) @(negedge CLK);
        check_out("en_drop", 0, 0, 0, 0, 31, 7, 1, 1);
        i_MBINIT_Start_en = 1'b1;
        send(h0_resp_n, 0);
        last(hdr1(h0_resp_n, 8'h00, 1'b0));
        check_out("after_drop", 1, 2, 0, 0, 31, 7, 1, 1);
        @(negedge CLK);

        // Asynchronous reset mid-packet
        send(h0_req_d, 0);
        send(hdr1(h0_req_d, 8'h00, 1'b1), 0);
        send(32'h0000_026F, 0);
        #2 rst_n = 1'b0;
        #1 check_out("rst_mid", 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge CLK);
        rst_n = 1'b1;
        @(negedge CLK);
        send(h0_req_d, 0);
        send(hdr1(h0_req_d, 8'h00, 1'b1), 0);
        send(32'h0000_026F, 0);
        last(32'h0);
        check_out("after_rst", 1, 1, 0, 0, 15, 3, 0, 1);
        @(negedge CLK);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/mbinit_param_sb_decoder.md
MBINIT_PARAM_SB_DECODER -- requirements
Module: mbinit_param_sb_decoder

Interface
REQ-001 SHALL have port CLK, input, 1, single clock for all logic.
REQ-002 SHALL have port rst_n, input, 1, reset; one clock, asynchronous assert, active-low.
REQ-003 SHALL have port i_MBINIT_Start_en, input, 1, decoding enabled while high.
REQ-004 SHALL have port i_sb_rx_valid, input, 1, marks i_sb_rx_data as one valid 32-bit sideband phase.
REQ-005 SHALL have port i_sb_rx_data, input, 32, sideband phase; phase0 first.
REQ-006 SHALL have port o_RX_SbMessage, output, 4, decoded message code.
REQ-007 SHALL have port o_msg_valid, output, 1, one-cycle pulse qualifying o_RX_SbMessage and the field outputs.
REQ-008 SHALL have ports o_RX_VoltageSwing (5), o_RX_MaxDataRate (3), o_RX_ClockMode (1) and o_RX_PhaseClock (1), all outputs, carrying the decoded PARAM data fields.
REQ-009 SHALL have ports o_parity_error and o_unknown_msg, outputs, 1 each, one-cycle error pulses.

Function
REQ-010 Phase0 fields SHALL be: opcode[4:0], msgcode[21:14]; phase1: dp[31], cp[30], msgsubcode[7:0].
REQ-011 Opcode 5'b10010 (message, no data) SHALL use 2 phases; opcode 5'b11011 (message, 64b data) SHALL use 4 phases; data phase0 bits [9:0] carry the fields, and data phase1 is ignored apart from parity.
REQ-012 FSM states SHALL be IDLE, HDR1, DATA0, DATA1, EMIT; phases advance only on cycles with i_sb_rx_valid=1, and gaps hold state.
REQ-013 IDLE->HDR1 SHALL occur on a valid phase while i_MBINIT_Start_en=1; HDR1->DATA0 if the opcode has data, otherwise HDR1->EMIT; DATA0->DATA1->EMIT; EMIT->IDLE unconditionally.
REQ-014 Any other opcode SHALL still consume 2 header phases, then pulse o_unknown_msg in EMIT with no o_msg_valid.
REQ-015 cp SHALL equal even parity over header bits excluding cp/dp; dp SHALL equal even parity over 64 data bits (0 if no data); a mismatch SHALL pulse o_parity_error in EMIT and suppress o_msg_valid.
REQ-016 Decode SHALL map msgcode 8'hA5 / subcode 8'h00 to PARAM_REQ=4'd1, and 8'hAA / 8'h00 to PARAM_RESP=4'd2; any other combination SHALL pulse o_unknown_msg.
REQ-017 Field mapping SHALL be VoltageSwing=[4:0], MaxDataRate=[7:5], ClockMode=[8], PhaseClock=[9].
REQ-018 Field outputs SHALL update only at EMIT with o_msg_valid and hold until the next valid message.
REQ-019 o_RX_SbMessage SHALL be driven only in the o_msg_valid cycle and be 4'd0 otherwise.
REQ-020 Latency from the last phase accepted to o_msg_valid SHALL be exactly 1 cycle.
REQ-021 A valid phase arriving in the EMIT cycle SHALL be accepted as phase0 of the next packet, giving back-to-back operation without loss.
REQ-022 i_MBINIT_Start_en falling mid-packet SHALL return the FSM to IDLE next cycle, discard the partial packet and produce no pulses.
REQ-023 A message without data SHALL leave the field outputs unchanged.

Reset
REQ-024 On rst_n=0, state SHALL be IDLE and all outputs and field registers SHALL be 0, asynchronously.
REQ-025 First packet accepted SHALL be the first valid phase after rst_n deasserts with i_MBINIT_Start_en=1.

Structure
REQ-026 Package mbinit_sb_pkg SHALL hold opcode constants, msgcode/subcode constants, 4-bit message code constants and FSM state encoding.
REQ-027 Parity SHALL be computed in sub-module sb_parity_chk (combinational XOR-reduce plus running dp accumulator register).

Verification
REQ-028 PARAM_REQ, phases {A5/opcode 11011, cp-correct, data 10'b1_0_011_01111, 0} -> o_msg_valid 1 cycle after phase 4, code 1, swing 15, rate 3, clkmode 0, phase 1.
REQ-029 PARAM_RESP without data (opcode 10010, msgcode AA) -> code 2 and fields unchanged from the previous message.
REQ-030 Same as REQ-028 with data bit0 flipped, dp unchanged -> o_parity_error pulse, no o_msg_valid, fields hold old values.
REQ-031 msgcode 8'h55 -> o_unknown_msg pulse, o_RX_SbMessage stays 0.
REQ-032 Two back-to-back packets with a phase in the EMIT cycle, plus i_sb_rx_valid gaps of 3 cycles -> two o_msg_valid pulses with correct fields.
REQ-033 i_MBINIT_Start_en dropped after phase 2, and rst_n asserted mid-packet -> no pulses, outputs 0 after reset, next packet decodes correctly.
